mat_seq_ctrl: RTL and testbench
===============================

MAT_SEQ_CTRL -- requirements
Module: mat_seq_ctrl

Interface
REQ-001 The block SHALL have parameter MAX_P, default 8, meaning the number of processor blocks sequenced (rows supported).
REQ-002 The block SHALL have parameter AW, default 4, meaning the RAM/vector address width.
REQ-003 The block SHALL have port clk  input  1  system clock; all logic rising-edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 The block SHALL have port start  input  1  request to run one matrix-vector product.
REQ-006 The block SHALL have port mat_size  input  4  matrix order N, valid range 1..MAX_P.
REQ-007 The block SHALL have port out_ready  input  1  result consumer ready.
REQ-008 The block SHALL have port abort  input  1  cancel request (see Configuration).
REQ-009 The block SHALL have port clr_acc  output  1  clear pulse to all processor accumulators.
REQ-010 The block SHALL have port en_op  output  1  operate enable to all processor blocks.
REQ-011 The block SHALL have port addr  output  AW  common RAM column / vector element index.
REQ-012 The block SHALL have port p_sel  output  3  processor whose OUTPUT is presented.
REQ-013 The block SHALL have port out_valid  output  1  p_sel result valid.
REQ-014 The block SHALL have ports busy, done, err  output  1 each  running, completion pulse, size-error pulse.

Function
REQ-015 The FSM SHALL have states IDLE, CLEAR, COMPUTE, DRAIN, FINISH.
REQ-016 In IDLE, start=1 with 1<=mat_size<=MAX_P SHALL latch N and go to CLEAR next cycle.
REQ-017 In IDLE, start=1 with mat_size=0 or >MAX_P SHALL pulse err for one cycle and remain IDLE.
REQ-018 CLEAR SHALL last exactly one cycle with clr_acc=1, addr=0, then go to COMPUTE.
REQ-019 COMPUTE SHALL last exactly N cycles with en_op=1 and addr=0,1,..,N-1 in successive cycles.
REQ-020 After addr=N-1, DRAIN SHALL start with p_sel=0, out_valid=1.
REQ-021 In DRAIN, p_sel SHALL advance only on the cycle where out_valid=1 and out_ready=1; p_sel and out_valid hold otherwise.
REQ-022 The handshake on p_sel=N-1 SHALL move to FINISH; FINISH SHALL pulse done=1 for one cycle, then go to IDLE.
REQ-023 busy SHALL be 1 in all states except IDLE.
REQ-024 start SHALL be ignored while busy=1; N SHALL not change mid-run even if mat_size changes.
REQ-025 en_op, clr_acc, out_valid, done, err SHALL be registered outputs; addr SHALL be 0 outside COMPUTE.
REQ-026 mat_size=1 SHALL give one COMPUTE cycle and one DRAIN handshake.
REQ-027 Counters SHALL never wrap; terminal count is N-1, compared in AW bits.

Reset
REQ-028 rst=0 at a clock edge SHALL force IDLE, N=0, all outputs 0, in any state including mid-COMPUTE or mid-DRAIN.
REQ-029 No done pulse SHALL be generated for a run interrupted by reset.

Configuration
REQ-030 With MAT_SEQ_ABORT_EN defined, abort=1 in any non-IDLE state SHALL force IDLE next cycle, all outputs 0, no done.
REQ-031 Without MAT_SEQ_ABORT_EN, the abort port SHALL exist but be ignored.

Structure
REQ-032 The state enum type, MAX_MAT_SIZE=8 and address width constant SHALL live in Definitions_Package.
REQ-033 One sub-module mat_seq_counter (load-zero, enable, terminal-count flag) SHALL be instantiated twice: column counter and processor counter.

Verification
REQ-034 N=4, start, out_ready=1 -> clr_acc at cycle 1, en_op cycles 2-5 with addr 0,1,2,3, out_valid p_sel 0..3 cycles 6-9, done at cycle 10.
REQ-035 N=3, out_ready low for 2 cycles at p_sel=1 -> p_sel holds 1, out_valid stays 1, done delayed 2 cycles.
REQ-036 mat_size=0 then 9 with start -> err pulses each time, busy stays 0.
REQ-037 rst=0 during COMPUTE addr=2 -> next cycle IDLE, en_op=0, addr=0, no done.
REQ-038 start pulses during run, mat_size changed to 2 mid-run with N=5 -> exactly 5 COMPUTE cycles, one done.
REQ-039 MAT_SEQ_ABORT_EN defined, abort in DRAIN -> IDLE next cycle, no done; undefined -> run completes normally.

Source files
------------

// File: rtl/mat_seq_ctrl_pkg.sv
// Shared definitions for the matrix-vector sequencer: FSM state encoding and size limits.
package Definitions_Package;

  localparam int MAX_MAT_SIZE = 8;
  localparam int ADDR_W       = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    COMPUTE = 3'd2,
    DRAIN   = 3'd3,
    FINISH  = 3'd4
  } state_t;

endpackage

// File: rtl/mat_seq_ctrl_counter.sv
// Up-counter with synchronous load-zero, enable and terminal-count flag.
// Saturates at the terminal value so it can never wrap.
module mat_seq_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] last,
  output logic [W-1:0] count,
  output logic         tc
);

  assign tc = (count == last);

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !tc) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/mat_seq_ctrl.sv
// Sequencer for an N x N matrix-vector product over MAX_P processor blocks.
// Optional feature: define MAT_SEQ_ABORT_EN to let abort cancel a run in progress.
module mat_seq_ctrl
  import Definitions_Package::*;
#(
  parameter int MAX_P = MAX_MAT_SIZE,
  parameter int AW    = ADDR_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [3:0]    mat_size,
  input  logic          out_ready,
  input  logic          abort,
  output logic          clr_acc,
  output logic          en_op,
  output logic [AW-1:0] addr,
  output logic [2:0]    p_sel,
  output logic          out_valid,
  output logic          busy,
  output logic          done,
  output logic          err,
  output state_t        fsm_state
);

  localparam logic [3:0] MAX_N = 4'(MAX_P);

  // Result handshake: a result is transferred on every cycle where out_valid
  // and out_ready are both high; out_valid and p_sel are held until then.

  state_t        state, state_next;
  logic [3:0]    n_reg, n_next;
  logic          err_next;
  logic          col_clr, col_en, col_tc;
  logic          proc_clr, proc_en, proc_tc;
  logic [AW-1:0] col_cnt, proc_cnt, last_idx;
  logic          size_ok;
  logic          unused_sig;

  assign size_ok    = (mat_size != 4'd0) && (mat_size <= MAX_N);
  assign last_idx   = AW'(n_reg) - AW'(1);
  assign unused_sig = ^{abort, proc_cnt};

  mat_seq_counter #(.W(AW)) u_col_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (col_clr),
    .en    (col_en),
    .last  (last_idx),
    .count (col_cnt),
    .tc    (col_tc)
  );

  mat_seq_counter #(.W(AW)) u_proc_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (proc_clr),
    .en    (proc_en),
    .last  (last_idx),
    .count (proc_cnt),
    .tc    (proc_tc)
  );

  always_comb begin
    state_next = state;
    n_next     = n_reg;
    err_next   = 1'b0;
    col_clr    = 1'b0;
    col_en     = 1'b0;
    proc_clr   = 1'b0;
    proc_en    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (size_ok) begin
            n_next     = mat_size;
            state_next = CLEAR;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      CLEAR: begin
        col_clr    = 1'b1;
        proc_clr   = 1'b1;
        state_next = COMPUTE;
      end
      COMPUTE: begin
        col_en = 1'b1;
        if (col_tc) state_next = DRAIN;
      end
      DRAIN: begin
        if (out_ready) begin
          proc_en = 1'b1;
          if (proc_tc) state_next = FINISH;
        end
      end
      FINISH: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
`ifdef MAT_SEQ_ABORT_EN
    if (abort && (state != IDLE)) state_next = IDLE;
`endif
  end

  // Strobes are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      n_reg     <= 4'd0;
      clr_acc   <= 1'b0;
      en_op     <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_next;
      n_reg     <= n_next;
      clr_acc   <= (state_next == CLEAR);
      en_op     <= (state_next == COMPUTE);
      out_valid <= (state_next == DRAIN);
      busy      <= (state_next != IDLE);
      done      <= (state_next == FINISH);
      err       <= err_next;
    end
  end

  assign addr      = (state == COMPUTE) ? col_cnt : '0;
  assign p_sel     = (state == DRAIN) ? proc_cnt[2:0] : 3'd0;
  assign fsm_state = state;

endmodule

// File: tb/tb_mat_seq_ctrl.sv
// Directed self-checking bench for mat_seq_ctrl; honours MAT_SEQ_ABORT_EN like the RTL.
module tb_mat_seq_ctrl;
  import Definitions_Package::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] mat_size;
  logic       out_ready;
  logic       abort;
  logic       clr_acc, en_op, out_valid, busy, done, err;
  logic [3:0] addr;
  logic [2:0] p_sel;
  state_t     fsm_state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mat_seq_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mat_size  (mat_size),
    .out_ready (out_ready),
    .abort     (abort),
    .clr_acc   (clr_acc),
    .en_op     (en_op),
    .addr      (addr),
    .p_sel     (p_sel),
    .out_valid (out_valid),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .fsm_state (fsm_state)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%04h exp=%04h", tag, got, exp);
    end
  endtask

  // {state, clr_acc, en_op, addr, p_sel, out_valid, busy, done, err}
  function automatic logic [15:0] pack(input int st, input int clr, input int en, input int ad,
                                       input int ps, input int ov, input int bz, input int dn,
                                       input int er);
    return {st[2:0], clr[0], en[0], ad[3:0], ps[2:0], ov[0], bz[0], dn[0], er[0]};
  endfunction

  function automatic logic [15:0] obs();
    return {3'(fsm_state), clr_acc, en_op, addr, p_sel, out_valid, busy, done, err};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full run of order n; the drain of processor stall_p sees out_ready low
  // for stall_len extra cycles. With noise set, start/mat_size (and abort when the
  // feature is off) are wiggled for the whole run and must have no effect.
  task automatic do_run(input string tag, input int n, input int stall_p, input int stall_len,
                        input bit noise);
    mat_size  = 4'(n);
    start     = 1'b1;
    out_ready = 1'b1;
    step();
    start = 1'b0;
    chk($sformatf("%s clear", tag), obs(), pack(int'(CLEAR), 1, 0, 0, 0, 0, 1, 0, 0));
    if (noise) begin
      start    = 1'b1;
      mat_size = 4'd2;
`ifndef MAT_SEQ_ABORT_EN
      abort = 1'b1;
`endif
    end
    for (int i = 0; i < n; i++) begin
      step();
      chk($sformatf("%s compute%0d", tag, i), obs(), pack(int'(COMPUTE), 0, 1, i, 0, 0, 1, 0, 0));
    end
    for (int p = 0; p < n; p++) begin
      step();
      chk($sformatf("%s drain%0d", tag, p), obs(), pack(int'(DRAIN), 0, 0, 0, p, 1, 1, 0, 0));
      if (p == stall_p) begin
        out_ready = 1'b0;
        for (int k = 0; k < stall_len; k++) begin
          step();
          chk($sformatf("%s stall%0d_%0d", tag, p, k), obs(),
              pack(int'(DRAIN), 0, 0, 0, p, 1, 1, 0, 0));
        end
        out_ready = 1'b1;
      end
    end
    step();
    chk($sformatf("%s finish", tag), obs(), pack(int'(FINISH), 0, 0, 0, 0, 0, 1, 1, 0));
    start = 1'b0;
    abort = 1'b0;
    step();
    chk($sformatf("%s idle", tag), obs(), pack(int'(IDLE), 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  initial begin
    rst       = 1'b0;
    start     = 1'b0;
    mat_size  = 4'd0;
    out_ready = 1'b1;
    abort     = 1'b0;
    step();
    step();
    chk("reset", obs(), pack(int'(IDLE), 0, 0, 0, 0, 0, 0, 0, 0));
    rst = 1'b1;
    step();
    chk("post_reset", obs(), pack(int'(IDLE), 0, 0, 0, 0, 0, 0, 0, 0));

    do_run("n4", 4, -1, 0, 1'b0);
    do_run("n3_stall", 3, 1, 2, 1'b0);

    // illegal sizes: err pulses, busy stays low
    mat_size = 4'd0;
    start    = 1'b1;
    step();
    chk("err_size0", obs(), pack(int'(IDLE), 0, 0, 0, 0, 0, 0, 0, 1));
    mat_size = 4'd9;
    step();
    chk("err_size9", obs(), pack(int'(IDLE), 0, 0, 0, 0, 0, 0, 0, 1));
    start = 1'b0;
    step();
    chk("err_clear", obs(), pack(int'(IDLE), 0, 0, 0, 0, 0, 0, 0, 0));

    do_run("n1", 1, -1, 0, 1'b0);
    do_run("n8", 8, 7, 1, 1'b0);

    // reset in the middle of COMPUTE
    mat_size = 4'd5;
    start    = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    chk("rst_mid_addr2", obs(), pack(int'(COMPUTE), 0, 1, 2, 0, 0, 1, 0, 0));
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("rst_mid_idle", obs(), pack(int'(IDLE), 0, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 10; k++) begin
      step();
      chk($sformatf("rst_no_done%0d", k), obs(), pack(int'(IDLE), 0, 0, 0, 0, 0, 0, 0, 0));
    end

    do_run("n5_noise", 5, -1, 0, 1'b1);

`ifdef MAT_SEQ_ABORT_EN
    mat_size = 4'd3;
    start    = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    step();
    chk("abort_drain0", obs(), pack(int'(DRAIN), 0, 0, 0, 0, 1, 1, 0, 0));
    out_ready = 1'b0;
    abort     = 1'b1;
    step();
    abort     = 1'b0;
    out_ready = 1'b1;
    chk("abort_idle", obs(), pack(int'(IDLE), 0, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 6; k++) begin
      step();
      chk($sformatf("abort_no_done%0d", k), obs(), pack(int'(IDLE), 0, 0, 0, 0, 0, 0, 0, 0));
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
